serial_adder_scheduler: RTL and testbench
=========================================

// Module: serial_adder_scheduler
// PURPOSE
//  Shares one NIB-bit ripple adder between two requesters to perform WIDTH-bit additions.
//  Each operation runs nibble-serially over WIDTH/NIB cycles, LSB nibble first, with a registered carry.
//  Round-robin arbitration decides which requester is served; a done pulse returns the result.
//  Sits between client logic and the shared 4-bit adder datapath; it is the only driver of that adder.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be a multiple of NIB
//  NIB    4   width of the shared adder; BEATS = WIDTH/NIB, the number of adder cycles per operation
// PORTS
//  clk      in   1      single clock; all state updates on the rising edge
//  rst      in   1      synchronous, active-high reset
//  req      in   2      req[i]=1: requester i has an addition pending; held high until gnt[i]
//  a0, b0   in   WIDTH  operands for requester 0; must be stable while req[0]=1
//  a1, b1   in   WIDTH  operands for requester 1; must be stable while req[1]=1
//  gnt      out  2      one-hot, one-cycle pulse: operands of requester i captured
//  busy     out  1      1 while an operation is in progress (states RUN and DONE)
//  done     out  1      one-cycle pulse: sum/cout valid for requester done_id
//  done_id  out  1      index of the requester whose result is on sum/cout
//  sum      out  WIDTH  result of the last completed operation; holds until next done
//  cout     out  1      carry out of the MSB nibble of the last completed operation
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, busy=0, done=0, done_id=0, sum=0, cout=0, carry=0, beat=0.
//   Round-robin pointer last=1, so requester 0 wins the first contention.
//  FSM: IDLE -> RUN -> DONE -> IDLE. All outputs are registered.
//  IDLE:
//   - If req!=0 at an edge, pick the winner:
//     - only one req bit set: that requester wins;
//     - both set: the requester != last wins.
//   - On that edge: capture the winner's a/b into shift registers, carry=0, beat=0, last=winner.
//     gnt[winner]=1 for the following cycle. Next state RUN.
//   - req==0: stay in IDLE.
//  RUN: each edge executes one beat.
//   - {c,s} = A[NIB-1:0] + B[NIB-1:0] + carry.
//   - s is shifted into the MSB nibble of the result register; A and B shift right by NIB.
//   - carry=c, beat=beat+1.
//   - After beat BEATS-1 (BEATS edges total): sum=result, cout=c, done_id=winner, done=1.
//     Next state DONE.
//  DONE: done=1 for exactly this cycle. Next state IDLE. Requests are not sampled in RUN or DONE.
//  Latency: gnt high in cycle g -> done high in cycle g+BEATS.
//   Back-to-back throughput is one operation per BEATS+2 cycles.
//  Arithmetic: modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1. The first beat's carry-in is 0.
//  Boundaries:
//   - req bit dropped before its grant: not served, no error.
//   - req still high after gnt: treated as a new request at the next IDLE.
//   - rst mid-RUN or mid-DONE: abort on that edge; no done is issued; sum/cout cleared.
//   - Operand changes after gnt do not affect the result in flight.
// STRUCTURE
//  Shared package: state encoding constants (ST_IDLE, ST_RUN, ST_DONE); BEATS = WIDTH/NIB;
//   beat counter width = clog2(BEATS).
//  Sub-module: adder_nibble — NIB-bit combinational adder (a, b, cin -> s, cout), instantiated once.
//   The arbiter, FSM and shift registers live in this module.
// TESTING
//  1. Reset, then req=01, a0=0x0001, b0=0x0001 -> gnt=01; 4 cycles later done=1, sum=0x0002, cout=0, done_id=0.
//  2. req=10, a1=0xFFFF, b1=0x0001 -> sum=0x0000, cout=1 (carry ripples across all 4 beats).
//  3. a0=0x1234, b0=0x4321 -> sum=0x5555, cout=0; check done exactly BEATS cycles after gnt and busy=1 throughout.
//  4. After reset, hold req=11 -> grants in order 01,10,01,10; done_id alternates 0,1,0,1; gap between gnts = BEATS+2.
//  5. Assert rst during beat 2 of a 0x8000+0x8000 operation -> next cycle busy=0, sum=0, cout=0; no done pulse.
//  6. Change a0 to 0xAAAA one cycle after gnt for a0=0x0F0F, b0=0x00F1 -> sum=0x1000, cout=0 (captured operands used).

Source files
------------

// File: rtl/serial_adder_scheduler_pkg.sv
// rtl/serial_adder_scheduler_pkg.sv - shared types and sizing helpers for the serial adder scheduler
package serial_adder_scheduler_pkg;

  // Scheduler FSM states: wait for a request, run the nibble beats, present the result
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NIB   = 4;
  localparam int DEF_BEATS = DEF_WIDTH / DEF_NIB;

  // Number of adder cycles needed for one WIDTH-bit operation
  function automatic int beats_of(input int width, input int nib);
    return width / nib;
  endfunction

  // Beat counter width; a single-beat configuration still gets a 1-bit counter
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_scheduler_adder_nibble.sv
// rtl/serial_adder_scheduler_adder_nibble.sv - NIB-bit combinational adder shared by both requesters
module adder_nibble #(
  parameter int NIB = 4
) (
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout
);

  // Zero-extend by one bit so the carry out falls into the top bit of the sum
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB{1'b0}}, cin};

endmodule

// File: rtl/serial_adder_scheduler.sv
// rtl/serial_adder_scheduler.sv - round-robin scheduler running WIDTH-bit adds nibble-serially on one adder
module serial_adder_scheduler
  import serial_adder_scheduler_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NIB   = DEF_NIB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int BEATS = beats_of(WIDTH, NIB);
  localparam int BW    = beat_cnt_w(BEATS);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [BW-1:0]    beat;
  logic             last;
  logic             cur;
  logic             win;
  logic [NIB-1:0]   nib_s;
  logic             nib_c;

  // Single instance of the shared adder, always fed from the low nibble of the operand shifters
  adder_nibble #(.NIB(NIB)) u_adder (
    .a    (a_sh[NIB-1:0]),
    .b    (b_sh[NIB-1:0]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Round-robin winner: a lone request wins outright, contention goes to the one not served last
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~last;
    else              win = req[1];
  end

  // Result register fills from the top so the LSB nibble ends up at the bottom after BEATS shifts
  always_comb begin
    res_next = '0;
    res_next = {nib_s, res[WIDTH-1:0]} >> NIB;
  end

  // Arbiter, beat sequencer and registered outputs in one FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      carry   <= 1'b0;
      beat    <= '0;
      last    <= 1'b1;
      cur     <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            cur   <= win;
            last  <= win;
            a_sh  <= win ? a1 : a0;
            b_sh  <= win ? b1 : b0;
            res   <= '0;
            carry <= 1'b0;
            beat  <= '0;
            gnt   <= win ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> NIB;
          b_sh  <= b_sh >> NIB;
          res   <= res_next;
          carry <= nib_c;
          beat  <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) begin
            sum     <= res_next;
            cout    <= nib_c;
            done_id <= cur;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_scheduler.sv
// tb/tb_serial_adder_scheduler.sv - self-checking bench for serial_adder_scheduler
module tb_serial_adder_scheduler;

  localparam int W     = 16;
  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy, done, done_id, cout;
  logic [W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  serial_adder_scheduler #(.WIDTH(W), .NIB(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: an op occupies BEATS+2 cycles from the grant edge,
  // its result is plain (WIDTH+1)-bit addition captured at the grant edge.
  bit         started = 0;
  bit         m_last;
  int         m_cnt;
  logic [W:0] m_pend;
  bit         m_pid;
  logic [1:0] e_gnt;
  logic       e_busy, e_done, e_id, e_cout;
  logic [W-1:0] e_sum;

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      m_last = 1; m_cnt = 0;
      e_gnt = 0; e_busy = 0; e_done = 0; e_id = 0; e_cout = 0; e_sum = 0;
    end else if (started) begin
      e_gnt = 0; e_done = 0;
      if (m_cnt == 0) begin
        if (req != 2'b00) begin
          m_pid  = (req == 2'b11) ? !m_last : req[1];
          m_last = m_pid;
          m_pend = m_pid ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
          e_gnt[m_pid] = 1'b1;
          e_busy = 1;
          m_cnt = BEATS + 1;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 1) begin
          e_done = 1; e_sum = m_pend[W-1:0]; e_cout = m_pend[W]; e_id = m_pid;
        end
        if (m_cnt == 0) e_busy = 0;
      end
    end
  end

  // Every cycle, compare all registered outputs against the reference
  always @(negedge clk) begin
    if (started) begin
      chk("gnt", gnt, e_gnt);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("done_id", done_id, e_id);
      chk("sum", sum, e_sum);
      chk("cout", cout, e_cout);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one single-requester op; optionally disturb the operand one cycle after the grant
  task automatic run_single(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit corrupt, output int lat, output logic [W-1:0] s,
                            output logic c, output logic id);
    if (who) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    req = who ? 2'b10 : 2'b01;
    tick();
    chk("t_gnt", gnt, who ? 2'b10 : 2'b01);
    req = 2'b00;
    lat = 0; s = '0; c = 1'b0; id = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (corrupt && k == 1) begin
        if (who) a1 = 16'hAAAA; else a0 = 16'hAAAA;
      end
      if (done) begin
        lat = k; s = sum; c = cout; id = done_id;
        break;
      end
      chk("t_busy_run", busy, 1'b1);
    end
    if (lat == 0) chk("t_done_timeout", 32'd0, 32'd1);
    tick();
  endtask

  int lat;
  logic [W-1:0] s;
  logic c, id;
  logic [1:0] gseq [4];
  int gcyc [4];
  logic dseq [3];

  initial begin
    int ng, nd, cyc;
    rst = 1; req = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick(); tick();
    chk("rst_gnt", gnt, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_sum", sum, 0); chk("rst_cout", cout, 0); chk("rst_id", done_id, 0);
    rst = 0;
    tick();

    run_single(0, 16'h0001, 16'h0001, 0, lat, s, c, id);
    chk("t1_lat", lat, BEATS); chk("t1_sum", s, 16'h0002); chk("t1_cout", c, 0); chk("t1_id", id, 0);
    run_single(1, 16'hFFFF, 16'h0001, 0, lat, s, c, id);
    chk("t2_sum", s, 16'h0000); chk("t2_cout", c, 1); chk("t2_id", id, 1);
    run_single(0, 16'h1234, 16'h4321, 0, lat, s, c, id);
    chk("t3_lat", lat, BEATS); chk("t3_sum", s, 16'h5555); chk("t3_cout", c, 0);
    run_single(0, 16'h0F0F, 16'h00F1, 1, lat, s, c, id);
    chk("t6_sum", s, 16'h1000); chk("t6_cout", c, 0);

    // Contention from reset: strict alternation, one grant every BEATS+2 cycles
    rst = 1; tick(); rst = 0;
    a0 = 16'h0001; b0 = 16'h0002; a1 = 16'h0003; b1 = 16'h0004;
    req = 2'b11;
    ng = 0; nd = 0; cyc = 0;
    while (ng < 4 && cyc < 60) begin
      tick(); cyc++;
      if (gnt != 0) begin gseq[ng] = gnt; gcyc[ng] = cyc; ng++; end
      if (done && nd < 3) begin dseq[nd] = done_id; nd++; end
    end
    req = 2'b00;
    chk("t4_ngrants", ng, 4);
    if (ng == 4) begin
      chk("t4_g0", gseq[0], 2'b01); chk("t4_g1", gseq[1], 2'b10);
      chk("t4_g2", gseq[2], 2'b01); chk("t4_g3", gseq[3], 2'b10);
      for (int k = 0; k < 3; k++) chk("t4_gap", gcyc[k+1] - gcyc[k], BEATS + 2);
      chk("t4_ndone", nd, 3);
      chk("t4_d0", dseq[0], 0); chk("t4_d1", dseq[1], 1); chk("t4_d2", dseq[2], 0);
    end
    repeat (8) tick();

    // Reset sampled on the beat-2 edge aborts the op with no done
    a0 = 16'h8000; b0 = 16'h8000; req = 2'b01;
    tick(); chk("t5_gnt", gnt, 2'b01); req = 2'b00;
    tick(); tick();
    rst = 1; tick(); rst = 0;
    chk("t5_busy", busy, 0); chk("t5_sum", sum, 0); chk("t5_cout", cout, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t5_nodone", done, 0);
    end

    // Randomized traffic checked by the reference on every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && gnt[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if (i == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
          else        begin a1 = W'($urandom); b1 = W'($urandom); end
          req[i] = 1'b1;
        end
      end
    end
    rst = 0; req = 0;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
